// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI3 bridge.
// Contents: FSM state enum, request-source enum, fixed AXI burst attributes,
// the kseg0/kseg1 address mask and a helper that recognises kseg addresses.
package sram_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_D  = 3'd2,
      WR_AW = 3'd3,
      WR_B  = 3'd4
   } state_t;

   typedef enum logic {
      SEL_INST = 1'b0,
      SEL_DATA = 1'b1
   } sel_t;

   localparam logic [2:0]  SIZE_WORD  = 3'd2;
   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [3:0]  LEN_1      = 4'd0;
   localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;

   // kseg0/kseg1 live at 0x8000_0000..0xBFFF_FFFF
   function automatic logic is_kseg(input logic [31:0] addr);
      return (addr[31:30] == 2'b10);
   endfunction

endpackage

// File: rtl/sram_axi_bridge_axi_addr_map.sv
// Core-to-bus address translation for the SRAM/AXI bridge.
// Optional feature macro: ADDR_MAP_EN
//   defined   : kseg0/kseg1 addresses (addr[31:30]=2'b10) are folded into the
//               low 512 MB by masking with 32'h1FFF_FFFF; others pass through.
//   undefined : every address passes through unchanged.
// Ports:
//   addr   - core-side byte address
//   mapped - bus-side byte address (combinational)
module sram_axi_bridge_axi_addr_map
   import sram_axi_bridge_pkg::*;
(
   input  logic [31:0] addr,
   output logic [31:0] mapped
);

`ifdef ADDR_MAP_EN
   // Fold unmapped kernel segments onto physical memory
   always_comb begin
      mapped = addr;
      if (is_kseg(addr)) begin
         mapped = addr & KSEG_MASK;
      end else begin
         mapped = addr;
      end
   end
`else
   assign mapped = addr;
`endif

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's single-beat SRAM-style inst and data ports onto one AXI3
// master with a single outstanding transaction. The data port has priority.
// The core sees x_stall = x_sram_en & ~x_done and advances in the one cycle
// where x_done pulses; x_sram_rdata is valid in that cycle.
// Optional feature macro: ADDR_MAP_EN (kseg address folding, see addr map).
// Ports:
//   clk, resetn             - clock, synchronous active-low reset
//   inst_sram_*             - instruction fetch request / read data / stall
//   data_sram_*             - load/store request / read data / stall
//   ar*, r*                 - AXI read address and read data channels
//   aw*, w*, b*             - AXI write address, write data, write response
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
#(
   parameter int          ID_W    = 4,
   parameter int unsigned INST_ID = 32'd0,
   parameter int unsigned DATA_ID = 32'd1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            inst_sram_en,
   input  logic [31:0]     inst_sram_addr,
   output logic [31:0]     inst_sram_rdata,
   output logic            inst_stall,
   input  logic            data_sram_en,
   input  logic [3:0]      data_sram_wen,
   input  logic [31:0]     data_sram_addr,
   input  logic [31:0]     data_sram_wdata,
   output logic [31:0]     data_sram_rdata,
   output logic            data_stall,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [3:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [3:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   state_t            state_r;
   sel_t              sel_r;
   logic [31:0]       addr_r;
   logic [31:0]       wdata_r;
   logic [3:0]        wstrb_r;
   logic [ID_W-1:0]   id_r;
   logic              arvalid_r;
   logic              rready_r;
   logic              awvalid_r;
   logic              wvalid_r;
   logic              bready_r;
   logic [31:0]       inst_rdata_r;
   logic [31:0]       data_rdata_r;
   logic              inst_done_r;
   logic              data_done_r;

   logic              data_req_s;
   logic              inst_req_s;
   logic              any_done_s;
   logic [31:0]       req_addr_s;
   logic [31:0]       req_addr_map_s;
   logic              aw_ok_s;
   logic              w_ok_s;
   logic              unused_s;

   // Single-beat responses: last flag, response codes and IDs carry no state
   assign unused_s = ^{rlast, rresp, bresp, rid, bid};

   // Pending-request decode and address selection (data wins)
   always_comb begin
      data_req_s = data_sram_en & ~data_done_r;
      inst_req_s = inst_sram_en & ~inst_done_r;
      any_done_s = inst_done_r | data_done_r;
      req_addr_s = inst_sram_addr;
      if (data_req_s) begin
         req_addr_s = data_sram_addr;
      end else begin
         req_addr_s = inst_sram_addr;
      end
   end

   sram_axi_bridge_axi_addr_map u_addr_map (
      .addr   (req_addr_s),
      .mapped (req_addr_map_s)
   );

   // A write channel is satisfied once its valid has already dropped or it
   // handshakes this cycle; AW and W may complete in either order.
   always_comb begin
      aw_ok_s = ~awvalid_r | awready;
      w_ok_s  = ~wvalid_r | wready;
   end

   // Bridge FSM with all AXI handshakes and core-side results registered
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r      <= IDLE;
         sel_r        <= SEL_INST;
         addr_r       <= 32'd0;
         wdata_r      <= 32'd0;
         wstrb_r      <= 4'd0;
         id_r         <= {ID_W{1'b0}};
         arvalid_r    <= 1'b0;
         rready_r     <= 1'b0;
         awvalid_r    <= 1'b0;
         wvalid_r     <= 1'b0;
         bready_r     <= 1'b0;
         inst_rdata_r <= 32'd0;
         data_rdata_r <= 32'd0;
         inst_done_r  <= 1'b0;
         data_done_r  <= 1'b0;
      end else begin
         // done flags are one-cycle pulses
         inst_done_r <= 1'b0;
         data_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // A done pulse means the core still holds the finished
               // request this cycle; starting now would re-issue it.
               if (!any_done_s && data_req_s) begin
                  addr_r  <= req_addr_map_s;
                  wdata_r <= data_sram_wdata;
                  wstrb_r <= data_sram_wen;
                  sel_r   <= SEL_DATA;
                  id_r    <= ID_W'(DATA_ID);
                  if (data_sram_wen != 4'b0000) begin
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state_r   <= WR_AW;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= RD_A;
                  end
               end else if (!any_done_s && inst_req_s) begin
                  addr_r    <= req_addr_map_s;
                  wstrb_r   <= 4'b0000;
                  sel_r     <= SEL_INST;
                  id_r      <= ID_W'(INST_ID);
                  arvalid_r <= 1'b1;
                  state_r   <= RD_A;
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_A: begin
               if (arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= RD_D;
               end else begin
                  state_r <= RD_A;
               end
            end
            RD_D: begin
               if (rvalid) begin
                  rready_r <= 1'b0;
                  state_r  <= IDLE;
                  if (sel_r == SEL_DATA) begin
                     data_rdata_r <= rdata;
                     data_done_r  <= 1'b1;
                  end else begin
                     inst_rdata_r <= rdata;
                     inst_done_r  <= 1'b1;
                  end
               end else begin
                  state_r <= RD_D;
               end
            end
            WR_AW: begin
               if (awvalid_r && awready) begin
                  awvalid_r <= 1'b0;
               end else begin
                  awvalid_r <= awvalid_r;
               end
               if (wvalid_r && wready) begin
                  wvalid_r <= 1'b0;
               end else begin
                  wvalid_r <= wvalid_r;
               end
               if (aw_ok_s && w_ok_s) begin
                  bready_r <= 1'b1;
                  state_r  <= WR_B;
               end else begin
                  state_r <= WR_AW;
               end
            end
            WR_B: begin
               if (bvalid) begin
                  bready_r    <= 1'b0;
                  data_done_r <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  state_r <= WR_B;
               end
            end
            default: begin
               arvalid_r <= 1'b0;
               rready_r  <= 1'b0;
               awvalid_r <= 1'b0;
               wvalid_r  <= 1'b0;
               bready_r  <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign inst_stall      = inst_sram_en & ~inst_done_r;
   assign data_stall      = data_sram_en & ~data_done_r;
   assign inst_sram_rdata = inst_rdata_r;
   assign data_sram_rdata = data_rdata_r;

   assign arid    = id_r;
   assign araddr  = addr_r;
   assign arlen   = LEN_1;
   assign arsize  = SIZE_WORD;
   assign arburst = BURST_INCR;
   assign arvalid = arvalid_r;
   assign rready  = rready_r;

   assign awid    = id_r;
   assign awaddr  = addr_r;
   assign awlen   = LEN_1;
   assign awsize  = SIZE_WORD;
   assign awburst = BURST_INCR;
   assign awvalid = awvalid_r;
   assign wdata   = wdata_r;
   assign wstrb   = wstrb_r;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_r;
   assign bready  = bready_r;

endmodule
